// File: rtl/serial_add_arb.sv
// Two-requester round-robin front end feeding a bit-serial adder.
// One operand pair is summed LSB first, one bit per clock, by a single full adder.
module serial_add_arb #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_sum,
  output logic             res_carry,
  output logic             res_id
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

  state_t           state;
  logic             last_grant;
  logic             grant_id;
  logic             accept;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] sum_reg;
  logic             carry_reg;
  logic             id_reg;
  logic [CW-1:0]    cnt;
  logic             bit_sum;
  logic             bit_carry;

  // Under contention the requester that lost the previous grant wins.
  always_comb begin
    if (req0_valid && req1_valid) grant_id = ~last_grant;
    else                          grant_id = req1_valid;
  end

  assign req0_ready = (state == IDLE) && !rst && req0_valid && !grant_id;
  assign req1_ready = (state == IDLE) && !rst && req1_valid &&  grant_id;
  assign accept     = req0_ready | req1_ready;

  assign bit_sum   = a_reg[0] ^ b_reg[0] ^ carry_reg;
  assign bit_carry = (a_reg[0] & b_reg[0]) | (a_reg[0] & carry_reg) | (b_reg[0] & carry_reg);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      a_reg      <= '0;
      b_reg      <= '0;
      sum_reg    <= '0;
      carry_reg  <= 1'b0;
      id_reg     <= 1'b0;
      cnt        <= '0;
      res_valid  <= 1'b0;
      res_sum    <= '0;
      res_carry  <= 1'b0;
      res_id     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            a_reg      <= grant_id ? req1_a : req0_a;
            b_reg      <= grant_id ? req1_b : req0_b;
            id_reg     <= grant_id;
            last_grant <= grant_id;
            sum_reg    <= '0;
            carry_reg  <= 1'b0;
            cnt        <= '0;
            state      <= ADD;
          end
        end
        ADD: begin
          // Operands shift down so bit 0 always feeds the adder; sum fills from the top.
          a_reg     <= a_reg >> 1;
          b_reg     <= b_reg >> 1;
          sum_reg   <= {bit_sum, sum_reg[WIDTH-1:1]};
          carry_reg <= bit_carry;
          cnt       <= cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1)) begin
            state     <= DONE;
            res_valid <= 1'b1;
            res_sum   <= {bit_sum, sum_reg[WIDTH-1:1]};
            res_carry <= bit_carry;
            res_id    <= id_reg;
          end
        end
        DONE: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/serial_add_arb.md
SERIAL_ADD_ARB -- requirements
Module: serial_add_arb

Interface
REQ-001 SHALL have parameter WIDTH, default 8, the operand and sum width in bits (legal range 2..32).
REQ-002 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have ports req0_valid, req1_valid  input  1 each  requester n presents an operand pair.
REQ-005 SHALL have ports req0_ready, req1_ready  output  1 each  requester n's pair is accepted this cycle.
REQ-006 SHALL have ports req0_a, req0_b, req1_a, req1_b  input  WIDTH each  addends from requester n.
REQ-007 SHALL have port res_valid  output  1  result available.
REQ-008 SHALL have port res_ready  input  1  consumer takes the result.
REQ-009 SHALL have port res_sum  output  WIDTH  sum, modulo 2^WIDTH.
REQ-010 SHALL have port res_carry  output  1  carry out of the MSB.
REQ-011 SHALL have port res_id  output  1  index of the requester that owns the result.

Function
REQ-012 SHALL implement a three-state FSM: IDLE, ADD and DONE.
REQ-013 SHALL assert reqN_ready only in IDLE, and only for the granted requester; at most one ready SHALL be high in any cycle.
REQ-014 SHALL grant, in IDLE, the sole valid requester; when both are valid, SHALL grant the requester that did not win the last grant (round-robin).
REQ-015 SHALL update the last-grant register only on an accept (reqN_valid && reqN_ready).
REQ-016 SHALL, on accept, capture a, b and the requester index into internal registers, clear the carry register and bit counter, and move to ADD.
REQ-017 SHALL ignore requester inputs after capture.
REQ-018 SHALL, in ADD, use a single 1-bit full adder that computes one bit per clock, LSB first: sum_i = a_i ^ b_i ^ c; c <= majority(a_i, b_i, c).
REQ-019 SHALL stay in ADD for exactly WIDTH rising edges and then move to DONE; res_valid SHALL be high in the cycle after the WIDTH-th ADD edge.
REQ-020 SHALL, in DONE, drive res_sum, res_carry and res_id from registers and hold them stable while res_ready is low.
REQ-021 SHALL, on res_valid && res_ready, return to IDLE; res_valid SHALL drop on that edge. The earliest next accept SHALL be one cycle later (no accept in DONE).
REQ-022 SHALL produce res_sum and res_carry such that {res_carry, res_sum} == a + b. Example for WIDTH=8: 0xFF+0x01 gives res_sum=0x00, res_carry=1.
REQ-023 SHALL keep res_valid low in IDLE and ADD, and hold res_sum/res_carry/res_id at their last completed values outside DONE.

Reset
REQ-024 SHALL, when rst is high at a rising edge, force IDLE and clear to 0: res_valid, res_sum, res_carry, res_id, the carry register, the bit counter and the captured operands.
REQ-025 SHALL reset the last-grant register to 1, so requester 0 wins the first contention.
REQ-026 SHALL abandon any operation in ADD or DONE on reset, with no result emitted; reqN_ready SHALL be low while rst is high.
REQ-027 SHALL allow an accept on the first edge after rst deasserts.

Verification (WIDTH=8)
REQ-028 SHALL cover: req0 3+5, res_ready=1 -> res_sum=0x08, res_carry=0, res_id=0, with res_valid high exactly 8 edges after the accept edge for one cycle.
REQ-029 SHALL cover: req1 0xFF+0x01 -> res_sum=0x00, res_carry=1, res_id=1; also 0xAA+0x55 -> 0xFF, carry 0.
REQ-030 SHALL cover: both requesters continuously valid from reset -> accepts alternate 0,1,0,1 and res_id follows the same sequence.
REQ-031 SHALL cover: res_ready held low 5 cycles in DONE -> res_sum/res_carry/res_id stable, both readies low; accept resumes one cycle after the res_ready handshake.
REQ-032 SHALL cover: rst pulsed at the 4th ADD edge -> no res_valid, outputs 0, and a new req0 accepted on the first edge after rst falls.
REQ-033 SHALL cover: requester operands changed on the cycle after accept -> result reflects the captured values only.
